row_compress_ctrl: RTL and testbench

Sequencer for the row-compression datapath. Accepts one row of `MAX_R_SIZE` words over a valid/ready handshake and holds it in a register. It then streams out the row's nonzero words one entry per cycle. Each entry is tagged with the count of zero words skipped before it (run-length distance) and a row-end flag. It sits between the row buffer feeding the compressor and the packed-word writer downstream.

---
 rtl/row_compress_ctrl_pkg.sv | 25 ++
 rtl/rc_lead_one.sv | 30 +++
 rtl/row_compress_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_row_compress_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/row_compress_ctrl_pkg.sv
// Shared definitions for the row-compression controller.
// Contents: FSM state encoding, run-length limit helper, index-width helper.
package row_compress_ctrl_pkg;

  localparam int unsigned DEF_WORD_WIDTH   = 8;
  localparam int unsigned DEF_MAX_R_SIZE   = 4;
  localparam int unsigned DEF_R_DIST_WIDTH = 2;
  localparam int unsigned DEF_CNT_WIDTH    = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  // Largest zero run a single entry's distance field can encode.
  function automatic int unsigned dmax(input int unsigned dist_w);
    return (32'd1 << dist_w) - 32'd1;
  endfunction

  // Bits needed to index n items (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/rc_lead_one.sv
// Combinational lowest-set-bit finder.
// Ports: mask (in)      - N-bit mask to search
//        idx_c (out)    - index of lowest set bit (0 if none)
//        found_c (out)  - at least one bit set
//        higher_c (out) - another set bit exists above idx_c
module rc_lead_one #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     mask,
  output logic [IDX_W-1:0] idx_c,
  output logic             found_c,
  output logic             higher_c
);

  // Scan high to low so the final hit is the lowest bit; any earlier hit is a higher bit.
  always_comb begin : find_lowest
    idx_c    = '0;
    found_c  = 1'b0;
    higher_c = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (mask[i]) begin
        higher_c = higher_c | found_c;
        found_c  = 1'b1;
        idx_c    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/row_compress_ctrl.sv
// Row-compression sequencer: accepts one row over valid/ready, then streams
// its nonzero words as (data, zero-run distance, last) entries.
// Ports: clk, reset_n           - clock, async active-low reset
//        in_valid/in_ready/in_data - row input handshake
//        out_valid/out_ready   - entry output handshake
//        out_data/out_dist/out_last/out_zero_row - entry payload
//        busy                  - row held and not fully emitted
//        rows_done             - wrapping count of completed rows
module row_compress_ctrl
  import row_compress_ctrl_pkg::*;
#(
  parameter int unsigned WORD_WIDTH   = DEF_WORD_WIDTH,
  parameter int unsigned MAX_R_SIZE   = DEF_MAX_R_SIZE,
  parameter int unsigned R_DIST_WIDTH = DEF_R_DIST_WIDTH,
  parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WORD_WIDTH*MAX_R_SIZE-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WORD_WIDTH-1:0]            out_data,
  output logic [R_DIST_WIDTH-1:0]          out_dist,
  output logic                             out_last,
  output logic                             out_zero_row,
  output logic                             busy,
  output logic [CNT_WIDTH-1:0]             rows_done
);

  localparam int unsigned ROW_W = WORD_WIDTH * MAX_R_SIZE;
  localparam int unsigned DMAX  = dmax(R_DIST_WIDTH);
  localparam int unsigned IDX_W = idx_width(MAX_R_SIZE);
  localparam int unsigned PTR_W = idx_width(MAX_R_SIZE + 1);

  state_e                  state_q, state_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [MAX_R_SIZE-1:0]   mask_q, mask_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;

  logic                    in_ready_d, busy_d, out_valid_d, out_last_d, out_zero_row_d;
  logic [WORD_WIDTH-1:0]   out_data_d;
  logic [R_DIST_WIDTH-1:0] out_dist_d;
  logic [CNT_WIDTH-1:0]    rows_done_d;

  logic [MAX_R_SIZE-1:0]   new_mask, scan_mask, gated;
  logic [ROW_W-1:0]        scan_row;
  logic [PTR_W-1:0]        scan_ptr;
  logic [IDX_W-1:0]        lo_idx;
  logic                    lo_found, lo_higher;
  logic [WORD_WIDTH-1:0]   sel_word;
  logic [31:0]             gap;
  logic                    load;

  // Scan source: the incoming row when accepting, else the residual held row.
  always_comb begin : scan_select
    new_mask = '0;
    for (int i = 0; i < int'(MAX_R_SIZE); i++) begin
      new_mask[i] = |in_data[i*WORD_WIDTH +: WORD_WIDTH];
    end
    if (state_q == ST_IDLE) begin
      scan_row  = in_data;
      scan_mask = new_mask;
      scan_ptr  = '0;
    end else begin
      scan_row  = row_q;
      scan_mask = mask_q;
      scan_ptr  = ptr_q;
    end
    gated = '0;
    for (int i = 0; i < int'(MAX_R_SIZE); i++) begin
      gated[i] = scan_mask[i] && (32'(i) >= 32'(scan_ptr));
    end
  end

  rc_lead_one #(
    .N     (MAX_R_SIZE),
    .IDX_W (IDX_W)
  ) u_lead_one (
    .mask     (gated),
    .idx_c    (lo_idx),
    .found_c  (lo_found),
    .higher_c (lo_higher)
  );

  // Word at the found index and its distance from the scan pointer.
  always_comb begin : word_pick
    sel_word = '0;
    for (int i = 0; i < int'(MAX_R_SIZE); i++) begin
      if (32'(i) == 32'(lo_idx)) sel_word = scan_row[i*WORD_WIDTH +: WORD_WIDTH];
    end
    gap = 32'(lo_idx) - 32'(scan_ptr);
  end

  // Next state, datapath and output-register values.
  always_comb begin : fsm_next
    state_d        = state_q;
    row_d          = row_q;
    mask_d         = mask_q;
    ptr_d          = ptr_q;
    out_valid_d    = out_valid;
    out_data_d     = out_data;
    out_dist_d     = out_dist;
    out_last_d     = out_last;
    out_zero_row_d = out_zero_row;
    rows_done_d    = rows_done;
    load           = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          row_d   = in_data;
          load    = 1'b1;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out_valid && out_ready) begin
          if (out_last) begin
            rows_done_d    = rows_done + CNT_WIDTH'(1);
            state_d        = ST_IDLE;
            out_valid_d    = 1'b0;
            out_data_d     = '0;
            out_dist_d     = '0;
            out_last_d     = 1'b0;
            out_zero_row_d = 1'b0;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Build the next entry; the mask/pointer registers track the row after it.
    if (load) begin
      out_valid_d = 1'b1;
      if (!lo_found) begin
        out_data_d     = '0;
        out_dist_d     = '0;
        out_last_d     = 1'b1;
        out_zero_row_d = 1'b1;
        mask_d         = '0;
        ptr_d          = '0;
      end else if (gap <= DMAX) begin
        out_data_d     = sel_word;
        out_dist_d     = R_DIST_WIDTH'(gap);
        out_last_d     = !lo_higher;
        out_zero_row_d = 1'b0;
        mask_d         = scan_mask & ~(MAX_R_SIZE'(1) << lo_idx);
        ptr_d          = PTR_W'(32'(lo_idx) + 32'd1);
      end else begin
        // Filler: DMAX zeros plus one zero word standing in for the data slot.
        out_data_d     = '0;
        out_dist_d     = R_DIST_WIDTH'(DMAX);
        out_last_d     = 1'b0;
        out_zero_row_d = 1'b0;
        mask_d         = scan_mask;
        ptr_d          = PTR_W'(32'(scan_ptr) + DMAX + 32'd1);
      end
    end

    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d == ST_EMIT);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin : regs
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      mask_q       <= '0;
      ptr_q        <= '0;
      in_ready     <= 1'b1;
      busy         <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_dist     <= '0;
      out_last     <= 1'b0;
      out_zero_row <= 1'b0;
      rows_done    <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      mask_q       <= mask_d;
      ptr_q        <= ptr_d;
      in_ready     <= in_ready_d;
      busy         <= busy_d;
      out_valid    <= out_valid_d;
      out_data     <= out_data_d;
      out_dist     <= out_dist_d;
      out_last     <= out_last_d;
      out_zero_row <= out_zero_row_d;
      rows_done    <= rows_done_d;
    end
  end

endmodule

// File: tb/tb_row_compress_ctrl.sv
// Directed bench for row_compress_ctrl: default instance plus an 8-word-row
// instance for the distance-overflow filler case.
module tb_row_compress_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_last, out_zero_row, busy;
  logic [31:0] in_data;
  logic [7:0]  out_data;
  logic [1:0]  out_dist;
  logic [15:0] rows_done;

  logic        in8_valid, in8_ready, out8_valid, out8_ready, out8_last, out8_zero_row, busy8;
  logic [63:0] in8_data;
  logic [7:0]  out8_data;
  logic [1:0]  out8_dist;
  logic [15:0] rows8_done;

  row_compress_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_dist(out_dist), .out_last(out_last), .out_zero_row(out_zero_row),
    .busy(busy), .rows_done(rows_done)
  );

  row_compress_ctrl #(.WORD_WIDTH(8), .MAX_R_SIZE(8), .R_DIST_WIDTH(2), .CNT_WIDTH(16)) dut8 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in8_valid), .in_ready(in8_ready), .in_data(in8_data),
    .out_valid(out8_valid), .out_ready(out8_ready), .out_data(out8_data),
    .out_dist(out8_dist), .out_last(out8_last), .out_zero_row(out8_zero_row),
    .busy(busy8), .rows_done(rows8_done)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] c_data [16];
  logic [1:0] c_dist [16];
  logic       c_last [16];
  logic       c_zr   [16];
  int         c_n;

  function automatic logic [31:0] mk_row(input logic [7:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  // Offer a row; returns #1 after the accepting edge.
  task automatic send_row(input logic [31:0] row, output bit ok);
    int  cyc;
    bit  acc;
    cyc = 0;
    acc = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = row;
    do begin
      @(negedge clk);
      cyc++;
      acc = in_ready;
      @(posedge clk); #1;
    end while (!acc && cyc < 100);
    in_valid = 1'b0;
    ok = acc;
  endtask

  // Record entries handshaken on the default instance, bounded.
  task automatic collect(input int n_exp);
    int cyc;
    cyc = 0;
    c_n = 0;
    while (c_n < n_exp && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (out_valid && out_ready) begin
        c_data[c_n] = out_data;
        c_dist[c_n] = out_dist;
        c_last[c_n] = out_last;
        c_zr[c_n]   = out_zero_row;
        c_n++;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in8_valid = 1'b0; in8_data = '0; out8_ready = 1'b0;
    #12;
    checks++;
    if ({out_valid, out_data, out_dist, out_last, out_zero_row, busy, rows_done} !== 30'd0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b d=%0d dist=%0d last=%b zr=%b busy=%b rows=%0d want all 0",
               out_valid, out_data, out_dist, out_last, out_zero_row, busy, rows_done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || in8_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release got in_ready=%b out_valid=%b busy=%b in8_ready=%b want 1 0 0 1",
               in_ready, out_valid, busy, in8_ready);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int ed[2] = '{1, 2};
    int es[2] = '{1, 1};
    int el[2] = '{0, 1};
    out_ready = 1'b1;
    send_row(mk_row(8'd0, 8'd1, 8'd0, 8'd2), ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_accept got timeout want accept"); end
    for (int e = 0; e < 2; e++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_data, out_dist, out_last, out_zero_row, busy, in_ready} !==
          {1'b1, 8'(ed[e]), 2'(es[e]), 1'(el[e]), 1'b0, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL basic_entry%0d got v=%b d=%0d dist=%0d last=%b zr=%b busy=%b rdy=%b want v=1 d=%0d dist=%0d last=%0d zr=0 busy=1 rdy=0",
                 e, out_valid, out_data, out_dist, out_last, out_zero_row, busy, in_ready, ed[e], es[e], el[e]);
      end
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle got in_ready=%b out_valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
    end
    checks++;
    if (rows_done !== 16'd1) begin
      failures++;
      $display("FAIL basic_rows_done got %0d want 1", rows_done);
    end
  endtask

  task automatic test_back_to_back();
    bit ok0, ok1, ok2;
    int ed[6] = '{3, 4, 5, 6, 7, 8};
    int es[6] = '{2, 0, 0, 0, 1, 2};
    int el[6] = '{0, 1, 0, 0, 1, 1};
    out_ready = 1'b1;
    fork
      begin
        send_row(mk_row(8'd0, 8'd0, 8'd3, 8'd4), ok0);
        send_row(mk_row(8'd5, 8'd6, 8'd0, 8'd7), ok1);
        send_row(mk_row(8'd0, 8'd0, 8'd8, 8'd0), ok2);
      end
      collect(6);
    join
    checks++;
    if (!(ok0 && ok1 && ok2) || c_n != 6) begin
      failures++;
      $display("FAIL b2b_count got accepts=%b%b%b entries=%0d want 111 entries=6", ok0, ok1, ok2, c_n);
    end
    for (int i = 0; i < c_n && i < 6; i++) begin
      checks++;
      if ({c_data[i], c_dist[i], c_last[i], c_zr[i]} !== {8'(ed[i]), 2'(es[i]), 1'(el[i]), 1'b0}) begin
        failures++;
        $display("FAIL b2b_entry%0d got (%0d,%0d,%b) zr=%b want (%0d,%0d,%0d) zr=0",
                 i, c_data[i], c_dist[i], c_last[i], c_zr[i], ed[i], es[i], el[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (rows_done !== 16'd4 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_rows_done got rows=%0d out_valid=%b want rows=4 out_valid=0", rows_done, out_valid);
    end
  endtask

  task automatic test_zero_row();
    bit ok;
    out_ready = 1'b1;
    send_row(32'd0, ok);
    collect(1);
    checks++;
    if (!ok || c_n != 1 || {c_data[0], c_dist[0], c_last[0], c_zr[0]} !== {8'd0, 2'd0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL zero_row_entry got n=%0d (%0d,%0d,%b) zr=%b want n=1 (0,0,1) zr=1",
               c_n, c_data[0], c_dist[0], c_last[0], c_zr[0]);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || rows_done !== 16'd5) begin
      failures++;
      $display("FAIL zero_row_done got out_valid=%b rows=%0d want 0 5", out_valid, rows_done);
    end
  endtask

  task automatic test_overflow();
    int  cyc, n;
    bit  acc;
    logic [7:0] d [4];
    logic [1:0] s [4];
    logic       l [4];
    logic       z [4];
    out8_ready = 1'b1;
    cyc = 0; n = 0; acc = 1'b0;
    @(posedge clk); #1;
    in8_valid = 1'b1;
    in8_data  = 64'h0900_0000_0000_0000;
    do begin
      @(negedge clk); cyc++; acc = in8_ready;
      @(posedge clk); #1;
    end while (!acc && cyc < 100);
    in8_valid = 1'b0;
    cyc = 0;
    while (n < 2 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (out8_valid && out8_ready) begin
        d[n] = out8_data; s[n] = out8_dist; l[n] = out8_last; z[n] = out8_zero_row; n++;
      end
    end
    checks++;
    if (!acc || n != 2) begin
      failures++;
      $display("FAIL overflow_count got accept=%b entries=%0d want 1 2", acc, n);
    end
    checks++;
    if (n > 0 && {d[0], s[0], l[0], z[0]} !== {8'd0, 2'd3, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL overflow_filler got (%0d,%0d,%b) zr=%b want (0,3,0) zr=0", d[0], s[0], l[0], z[0]);
    end
    checks++;
    if (n > 1 && {d[1], s[1], l[1], z[1]} !== {8'd9, 2'd3, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL overflow_word got (%0d,%0d,%b) zr=%b want (9,3,1) zr=0", d[1], s[1], l[1], z[1]);
    end
    @(negedge clk);
    checks++;
    if (out8_valid !== 1'b0 || rows8_done !== 16'd1) begin
      failures++;
      $display("FAIL overflow_done got out_valid=%b rows=%0d want 0 1", out8_valid, rows8_done);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int ed[3] = '{5, 6, 7};
    int es[3] = '{0, 0, 1};
    int el[3] = '{0, 0, 1};
    out_ready = 1'b0;
    send_row(mk_row(8'd5, 8'd6, 8'd0, 8'd7), ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_accept got timeout want accept"); end
    for (int e = 0; e < 3; e++) begin
      for (int st = 0; st < 3; st++) begin
        @(negedge clk);
        if (st == 0) out_ready = 1'b0;
        checks++;
        if ({out_valid, out_data, out_dist, out_last, out_zero_row, busy, in_ready} !==
            {1'b1, 8'(ed[e]), 2'(es[e]), 1'(el[e]), 1'b0, 1'b1, 1'b0}) begin
          failures++;
          $display("FAIL bp_entry%0d_cyc%0d got v=%b (%0d,%0d,%b) zr=%b busy=%b rdy=%b want v=1 (%0d,%0d,%0d) zr=0 busy=1 rdy=0",
                   e, st, out_valid, out_data, out_dist, out_last, out_zero_row, busy, in_ready, ed[e], es[e], el[e]);
        end
        if (st == 2) out_ready = 1'b1;
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || rows_done !== 16'd6 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_done got out_valid=%b rows=%0d in_ready=%b want 0 6 1", out_valid, rows_done, in_ready);
    end
  endtask

  task automatic test_reset_mid_row();
    bit ok;
    out_ready = 1'b1;
    send_row(mk_row(8'd5, 8'd6, 8'd0, 8'd7), ok);
    @(negedge clk);
    checks++;
    if (!ok || {out_valid, out_data, out_dist, out_last} !== {1'b1, 8'd5, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL mid_first_entry got ok=%b v=%b (%0d,%0d,%b) want 1 v=1 (5,0,0)",
               ok, out_valid, out_data, out_dist, out_last);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_dist, out_last, out_zero_row, busy, rows_done} !== 30'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_outputs got v=%b d=%0d dist=%0d last=%b zr=%b busy=%b rows=%0d rdy=%b want all 0 rdy=1",
               out_valid, out_data, out_dist, out_last, out_zero_row, busy, rows_done, in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    send_row(mk_row(8'd0, 8'd1, 8'd0, 8'd2), ok);
    collect(2);
    checks++;
    if (!ok || c_n != 2 ||
        {c_data[0], c_dist[0], c_last[0], c_data[1], c_dist[1], c_last[1]} !==
        {8'd1, 2'd1, 1'b0, 8'd2, 2'd1, 1'b1}) begin
      failures++;
      $display("FAIL mid_next_row got n=%0d (%0d,%0d,%b) (%0d,%0d,%b) want n=2 (1,1,0) (2,1,1)",
               c_n, c_data[0], c_dist[0], c_last[0], c_data[1], c_dist[1], c_last[1]);
    end
    @(negedge clk);
    checks++;
    if (rows_done !== 16'd1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_rows_done got rows=%0d out_valid=%b want 1 0", rows_done, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_row();
    test_overflow();
    test_backpressure();
    test_reset_mid_row();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
